// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address/count width derivation and default geometry.
package fifo_pkg;

  localparam int DEF_DWID  = 16;
  localparam int DEF_DEPTH = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DWID = 16,
  parameter int AWID = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AWID-1:0] waddr,
  input  logic [DWID-1:0] wdata,
  input  logic [AWID-1:0] raddr,
  output logic [DWID-1:0] rdata
);

  logic [DWID-1:0] mem [1 << AWID];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy count, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int DWID      = DEF_DWID,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_write,
  input  logic [DWID-1:0]           i_din,
  output logic                      o_full,
  output logic                      o_afull,
  input  logic                      i_read,
  output logic [DWID-1:0]           o_dout,
  output logic                      o_empty,
  output logic                      o_aempty,
  output logic [count_w(DEPTH)-1:0] o_count,
  output logic                      o_overflow,
  output logic                      o_underflow,
  input  logic                      i_clr_err
);

  localparam int AWID = clog2(DEPTH);
  localparam int CW   = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [AWID-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [DWID-1:0] ram_rdata;
  logic            wr_en, rd_en;

  // Acceptance uses the registered flags, so a full FIFO never passes a write through.
  assign wr_en = i_write && !o_full;
  assign rd_en = i_read  && !o_empty;

  always_comb begin
    count_nxt = o_count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = o_count + 1'b1;
      2'b01:   count_nxt = o_count - 1'b1;
      default: count_nxt = o_count;
    endcase
  end

  fifo_ram #(
    .DWID(DWID),
    .AWID(AWID)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(i_din),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  // Flags are registered from the next count so they always match o_count exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_full      <= 1'b0;
      o_afull     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      o_count  <= count_nxt;
      o_empty  <= (count_nxt == '0);
      o_aempty <= (count_nxt <= AEMPTY_C);
      o_full   <= (count_nxt == DEPTH_C);
      o_afull  <= (count_nxt >= AFULL_C);
      // A new error in the same cycle as a clear request wins.
      if (i_write && o_full)  o_overflow  <= 1'b1;
      else if (i_clr_err)     o_overflow  <= 1'b0;
      if (i_read && o_empty)  o_underflow <= 1'b1;
      else if (i_clr_err)     o_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible combinationally; forced to zero while empty.
  assign o_dout = o_empty ? '0 : ram_rdata;
`else
  logic [DWID-1:0] dout_p0;

  always_ff @(posedge clk) begin
    if (rst)        dout_p0 <= '0;
    else if (rd_en) dout_p0 <= ram_rdata;
  end

  assign o_dout = dout_p0;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed self-checking bench for sync_fifo_level (both output modes via SYNC_FIFO_FWFT_EN).
module tb_sync_fifo_level;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_write = 1'b0, i_read = 1'b0, i_clr_err = 1'b0;
  logic [15:0] i_din = '0;
  logic        o_full, o_afull, o_empty, o_aempty, o_overflow, o_underflow;
  logic [15:0] o_dout;
  logic [8:0]  o_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sync_fifo_level #(
    .DWID(16), .DEPTH(256), .AFULL_TH(240), .AEMPTY_TH(16)
  ) dut (
    .clk(clk), .rst(rst), .i_write(i_write), .i_din(i_din), .o_full(o_full),
    .o_afull(o_afull), .i_read(i_read), .o_dout(o_dout), .o_empty(o_empty),
    .o_aempty(o_aempty), .o_count(o_count), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .i_clr_err(i_clr_err)
  );

  // Apply one cycle of inputs; returns 1 time unit after the edge with inputs idle.
  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
    i_write = w; i_din = d; i_read = r; i_clr_err = c;
    @(posedge clk); #1;
    i_write = 1'b0; i_read = 1'b0; i_clr_err = 1'b0;
  endtask

  // Read one entry, checking it against exp at the point each mode presents it.
  task automatic read_check(input logic [15:0] exp, input logic w, input logic [15:0] d);
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (o_dout !== exp) begin errors++; $display("FAIL read_data: got %h expected %h", o_dout, exp); end
    step(w, d, 1'b1, 1'b0);
`else
    step(w, d, 1'b1, 1'b0);
    checks++; if (o_dout !== exp) begin errors++; $display("FAIL read_data: got %h expected %h", o_dout, exp); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (o_empty !== 1'b1)  begin errors++; $display("FAIL rst_empty: got %b expected 1", o_empty); end
    checks++; if (o_aempty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b expected 1", o_aempty); end
    checks++; if (o_full !== 1'b0)   begin errors++; $display("FAIL rst_full: got %b expected 0", o_full); end
    checks++; if (o_afull !== 1'b0)  begin errors++; $display("FAIL rst_afull: got %b expected 0", o_afull); end
    checks++; if (o_count !== 9'd0)  begin errors++; $display("FAIL rst_count: got %0d expected 0", o_count); end
    checks++; if (o_dout !== 16'h0)  begin errors++; $display("FAIL rst_dout: got %h expected 0000", o_dout); end
    checks++; if ({o_overflow, o_underflow} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", {o_overflow, o_underflow}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      checks++; if (o_count !== 9'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", o_count, i + 1); end
      checks++; if (o_aempty !== (i + 1 <= 16)) begin errors++; $display("FAIL fill_aempty at %0d: got %b", i + 1, o_aempty); end
      checks++; if (o_afull !== (i + 1 >= 240)) begin errors++; $display("FAIL fill_afull at %0d: got %b", i + 1, o_afull); end
      checks++; if (o_full !== (i + 1 == 256)) begin errors++; $display("FAIL fill_full at %0d: got %b", i + 1, o_full); end
      checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL fill_empty at %0d: got %b expected 0", i + 1, o_empty); end
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (o_dout !== 16'h0) begin errors++; $display("FAIL fwft_head: got %h expected 0000", o_dout); end
`endif
    end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", o_overflow); end
    checks++; if (o_count !== 9'd256) begin errors++; $display("FAIL ovf_count: got %0d expected 256", o_count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 256; i++) begin
      read_check(16'(i), 1'b0, 16'h0);
      checks++; if (o_count !== 9'(255 - i)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", o_count, 255 - i); end
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", o_empty); end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", o_underflow); end
    checks++; if (o_count !== 9'd0) begin errors++; $display("FAIL udf_count: got %0d expected 0", o_count); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (o_dout !== 16'd255) begin errors++; $display("FAIL udf_hold: got %h expected 00ff", o_dout); end
`endif
    step(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if ({o_overflow, o_underflow} !== 2'b00) begin errors++; $display("FAIL clr_err: got %b expected 00", {o_overflow, o_underflow}); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 200; i++) step(1'b1, 16'(16'h1000 + k * 200 + i), 1'b0, 1'b0);
      checks++; if (o_count !== 9'd200) begin errors++; $display("FAIL wrap_count: got %0d expected 200", o_count); end
      for (int i = 0; i < 200; i++) read_check(16'(16'h1000 + k * 200 + i), 1'b0, 16'h0);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", o_empty); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 100; i++) step(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      read_check(16'(16'h2000 + i), 1'b1, 16'(16'h2000 + 100 + i));
      checks++; if (o_count !== 9'd100) begin errors++; $display("FAIL simul_count: got %0d expected 100", o_count); end
    end
    // Entries 50..149 present; top up to full with 150..305.
    for (int i = 150; i < 306; i++) step(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL simul_full: got %b expected 1", o_full); end
    step(1'b1, 16'hBAD0, 1'b0, 1'b1);
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL set_wins_clr: got %b expected 1", o_overflow); end
    step(1'b0, 16'h0, 1'b0, 1'b1);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", o_overflow); end
    read_check(16'h2000 + 16'd50, 1'b1, 16'hBAD1);
    checks++; if (o_count !== 9'd255) begin errors++; $display("FAIL full_rw_count: got %0d expected 255", o_count); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL full_rw_ovf: got %b expected 1", o_overflow); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_rw_full: got %b expected 0", o_full); end
    for (int i = 51; i < 306; i++) read_check(16'(16'h2000 + i), 1'b0, 16'h0);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b expected 1", o_empty); end
    step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 37; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
    checks++; if (o_count !== 9'd37) begin errors++; $display("FAIL mid_pre_count: got %0d expected 37", o_count); end
    rst = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (o_count !== 9'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", o_count); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", o_empty); end
    checks++; if (o_dout !== 16'h0) begin errors++; $display("FAIL mid_dout: got %h expected 0000", o_dout); end
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    checks++; if (o_count !== 9'd1) begin errors++; $display("FAIL mid_new_count: got %0d expected 1", o_count); end
    read_check(16'h1234, 1'b0, 16'h0);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL mid_new_empty: got %b expected 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
